if_store_ctrl: RTL and testbench
================================

# if_store_ctrl

Input-feature store engine that sits directly downstream of the schedule controller. It consumes the one-shot `start_if_store` request and returns `if_store_busy` / `if_store_done`. While running, it accepts one input-feature tile from a valid/ready stream and writes it row-interleaved into a bank of line-buffer SRAMs, with row r going to bank r mod NUM_BANK. It also checks the stream's `s_last` marker against the expected tile length.

## Interface
- DATA_W, 64: width of one stream/SRAM word
- ROW_WORDS, 8: words per feature row (one bank write per word)
- TILE_ROWS, 6: rows per tile; total words per tile = TILE_ROWS*ROW_WORDS (48)
- NUM_BANK, 3: line-buffer SRAM banks
- ADDR_W, 8: per-bank address width; must hold ceil(TILE_ROWS/NUM_BANK)*ROW_WORDS-1
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- start_if_store  in  1  request from scheduler; may stay high up to 2 cycles
- if_store_busy  out  1  high while a tile is being accepted/written
- if_store_done  out  1  one-cycle pulse after the last SRAM write
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_last  in  1  marks the final word of the tile
- s_ready  out  1  engine accepts a word this cycle
- sram_wen  out  1  write strobe, active high
- sram_bank_sel  out  NUM_BANK  one-hot bank select, valid with `sram_wen`
- sram_addr  out  ADDR_W  in-bank word address
- sram_wdata  out  DATA_W  write data
- if_store_err  out  1  sticky: `s_last` mismatch seen in the current/last tile

## Operation
- FSM states:
  - IDLE → LOAD on `start_if_store`.
  - LOAD → FLUSH on the handshake of word TILE_ROWS*ROW_WORDS-1.
  - FLUSH → DONE unconditionally.
  - DONE → IDLE unconditionally.
- `start_if_store` is ignored in LOAD, FLUSH and DONE. It is never queued.
- `s_ready` = (state == LOAD), driven from the registered state, so there is no combinational path from `s_valid`. A handshake is `s_valid & s_ready`.
- Counters, all cleared on entry to LOAD:
  - `col` (0..ROW_WORDS-1)
  - `bank` (0..NUM_BANK-1)
  - `bank_row` (row / NUM_BANK)
  - `word_cnt`
- On each handshake:
  - `col` increments.
  - When `col` wraps, `bank` increments.
  - When `bank` wraps, `bank_row` increments.
  - No divider or multiplier is used; the address is computed as a running `bank_row*ROW_WORDS` base plus `col`.
- Write address = `bank_row*ROW_WORDS + col`. Bank = row mod NUM_BANK.
- `s_last` check:
  - `s_last` = 1 on any word other than the final one sets `if_store_err`.
  - `s_last` = 0 on the final word also sets `if_store_err`.
  - The tile length is fixed by parameters. The engine never ends early on `s_last`.
- `if_store_err` clears on entry to LOAD and otherwise holds.
- `if_store_busy` = (state == LOAD || state == FLUSH), registered.

## Timing
- Reset: all outputs are 0.
  - `sram_bank_sel` = 0, `sram_addr` = 0, `sram_wdata` = 0.
  - FSM returns to IDLE and all counters clear.
- Reset during LOAD/FLUSH aborts the tile:
  - No `if_store_done`.
  - A `sram_wen` pulse pending at the reset edge is dropped.
- Start sampled at edge t:
  - `if_store_busy` = 1 and `s_ready` = 1 from cycle t+1.
  - A start still high at t+1 is ignored.
- Write latency: a handshake at edge k puts `sram_wen` = 1 with its bank/addr/data in cycle k+1 (exactly one write per handshake, in order).
- A word is accepted every cycle while `s_valid` = 1 (full throughput). Gaps in `s_valid` produce gaps in `sram_wen`.
- Final handshake at edge k:
  - FLUSH in cycle k+1: last write visible, `s_ready` = 0.
  - DONE in cycle k+2: `if_store_done` = 1, `if_store_busy` = 0.
  - IDLE in cycle k+3.
- `if_store_done` and `if_store_busy` are never high together.
- A start during the DONE cycle is ignored. The earliest accepted restart is sampled in IDLE, i.e. cycle k+3.

## Test plan
- Reset hold: assert `reset` = 0 for 3 cycles with random inputs → all outputs 0 and `s_ready` = 0.
- Start asserted 2 cycles, then 48 back-to-back words (data = index, `s_last` on word 47):
  - `if_store_busy` rises 1 cycle after the first start cycle.
  - 48 writes, the first one cycle after the first handshake.
  - Word 37 (row 4, col 5) → bank_sel = 3'b010, addr = 13, data = 37.
  - Word 47 → bank_sel = 3'b100, addr = 15.
  - `if_store_done` is a single pulse 2 cycles after the last handshake; `if_store_err` = 0.
- Random `s_valid` bubbles (≈50%): the write sequence is identical to the back-to-back case; `sram_wen` count = 48; done timing is relative to the last handshake.
- `s_last` asserted early on word 20:
  - `if_store_err` = 1 from the write of word 20.
  - Engine still takes 48 words and then pulses done.
  - `if_store_err` clears when the next tile starts.
- Reset = 0 mid-tile after word 30, then restart: no done pulse for the aborted tile; the restarted tile writes word 0 to bank0, addr 0.
- Start pulsed in the DONE cycle and again in the following IDLE cycle → the first is ignored and the second launches a new tile (busy next cycle).

Source files
------------

// File: rtl/if_store_ctrl.sv
// if_store_ctrl: input-feature store engine.
// Takes a one-shot start from the scheduler, accepts one tile of TILE_ROWS*ROW_WORDS words
// from a valid/ready stream and writes it row-interleaved into NUM_BANK line-buffer SRAMs
// (row r -> bank r mod NUM_BANK). The stream's s_last marker is checked against the fixed
// tile length; any mismatch sets a sticky error flag.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   start_if_store             start request (level may last up to 2 cycles)
//   if_store_busy / _done      busy while loading/flushing, one-cycle done pulse
//   s_valid/s_data/s_last/s_ready   input word stream
//   sram_wen/bank_sel/addr/wdata    registered SRAM write port, one-hot bank select
//   if_store_err               sticky s_last mismatch flag, cleared on next tile start
module if_store_ctrl #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ROW_WORDS = 8,
  parameter int unsigned TILE_ROWS = 6,
  parameter int unsigned NUM_BANK  = 3,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_if_store,
  output logic                if_store_busy,
  output logic                if_store_done,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic                sram_wen,
  output logic [NUM_BANK-1:0] sram_bank_sel,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic                if_store_err
);

  localparam int unsigned TileWords = TILE_ROWS * ROW_WORDS;
  localparam int unsigned ColW      = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int unsigned BankW     = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  // One extra bit so the count can reach TileWords without wrapping.
  localparam int unsigned CntW      = $clog2(TileWords + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e              state_q;
  logic [ColW-1:0]     col_q;
  logic [BankW-1:0]    bank_q;
  logic [ADDR_W-1:0]   row_base_q;  // bank_row * ROW_WORDS, kept as a running sum
  logic [CntW-1:0]     word_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                handshake;
  logic                last_word;
  logic                col_wrap;
  logic                bank_wrap;
  logic [NUM_BANK-1:0] bank_onehot;

  always_comb begin
    handshake   = s_valid && (state_q == StLoad);
    last_word   = (word_cnt_q == CntW'(TileWords - 1));
    col_wrap    = (col_q == ColW'(ROW_WORDS - 1));
    bank_wrap   = (bank_q == BankW'(NUM_BANK - 1));
    bank_onehot = NUM_BANK'(1) << bank_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      col_q         <= '0;
      bank_q        <= '0;
      row_base_q    <= '0;
      word_cnt_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      sram_wen      <= 1'b0;
      sram_bank_sel <= '0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
    end else begin
      sram_wen <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_if_store) begin
            state_q    <= StLoad;
            busy_q     <= 1'b1;
            col_q      <= '0;
            bank_q     <= '0;
            row_base_q <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
          end
        end
        StLoad: begin
          if (handshake) begin
            sram_wen      <= 1'b1;
            sram_bank_sel <= bank_onehot;
            sram_addr     <= row_base_q + ADDR_W'(col_q);
            sram_wdata    <= s_data;
            // Length is fixed by parameters; s_last is only checked, never obeyed.
            if (s_last != last_word) begin
              err_q <= 1'b1;
            end
            word_cnt_q <= word_cnt_q + CntW'(1);
            if (col_wrap) begin
              col_q <= '0;
              if (bank_wrap) begin
                bank_q     <= '0;
                row_base_q <= row_base_q + ADDR_W'(ROW_WORDS);
              end else begin
                bank_q <= bank_q + BankW'(1);
              end
            end else begin
              col_q <= col_q + ColW'(1);
            end
            if (last_word) begin
              state_q <= StFlush;
            end
          end
        end
        StFlush: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready       = (state_q == StLoad);
  assign if_store_busy = busy_q;
  assign if_store_done = done_q;
  assign if_store_err  = err_q;

endmodule

// File: tb/tb_if_store_ctrl.sv
module tb_if_store_ctrl;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ROW_WORDS = 8;
  localparam int unsigned TILE_ROWS = 6;
  localparam int unsigned NUM_BANK  = 3;
  localparam int unsigned ADDR_W    = 8;
  localparam int          TILE      = TILE_ROWS * ROW_WORDS;

  logic                clk = 1'b0;
  logic                reset;
  logic                start_if_store;
  logic                if_store_busy;
  logic                if_store_done;
  logic                s_valid;
  logic [DATA_W-1:0]   s_data;
  logic                s_last;
  logic                s_ready;
  logic                sram_wen;
  logic [NUM_BANK-1:0] sram_bank_sel;
  logic [ADDR_W-1:0]   sram_addr;
  logic [DATA_W-1:0]   sram_wdata;
  logic                if_store_err;

  if_store_ctrl #(
    .DATA_W   (DATA_W),
    .ROW_WORDS(ROW_WORDS),
    .TILE_ROWS(TILE_ROWS),
    .NUM_BANK (NUM_BANK),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_if_store(start_if_store),
    .if_store_busy (if_store_busy),
    .if_store_done (if_store_done),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .sram_wen      (sram_wen),
    .sram_bank_sel (sram_bank_sel),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .if_store_err  (if_store_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the engine as seen from outside, in terms of words taken and
  // cycles elapsed since the final word.
  bit m_acc   = 1'b0;  // accepting words
  int m_taken = 0;     // words accepted in current tile
  int m_after = 0;     // 0: none, 1: cycle after final word, 2: done cycle
  bit m_err   = 1'b0;
  int wen_count = 0;

  logic [NUM_BANK-1:0] cap_sel  [TILE];
  logic [ADDR_W-1:0]   cap_addr [TILE];
  logic [DATA_W-1:0]   cap_data [TILE];

  typedef struct {
    int                  idx;
    logic [NUM_BANK-1:0] sel;
    logic [ADDR_W-1:0]   addr;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NUM_BANK-1:0] exp_sel(input int i);
    int row;
    row = i / ROW_WORDS;
    return NUM_BANK'(1 << (row % NUM_BANK));
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input int i);
    int row;
    row = i / ROW_WORDS;
    return ADDR_W'((row / NUM_BANK) * ROW_WORDS + (i % ROW_WORDS));
  endfunction

  // One clock cycle: drive inputs, advance, update model, compare everything.
  task automatic cyc(input logic rn, input logic v, input logic [DATA_W-1:0] d,
                     input logic l, input logic st);
    bit hs;
    bit go;
    int idx;
    reset          = rn;
    s_valid        = v;
    s_data         = d;
    s_last         = l;
    start_if_store = st;
    hs  = rn && m_acc && v;
    go  = rn && st && !m_acc && (m_after == 0);
    idx = m_taken;
    @(posedge clk);
    #1;
    if (!rn) begin
      m_acc   = 1'b0;
      m_after = 0;
      m_err   = 1'b0;
      m_taken = 0;
    end else begin
      if (m_after > 0) m_after++;
      if (m_after == 3) m_after = 0;
      if (hs) begin
        if (l != (idx == TILE - 1)) m_err = 1'b1;
        m_taken++;
        if (m_taken == TILE) begin
          m_acc   = 1'b0;
          m_after = 1;
        end
      end
      if (go) begin
        m_acc   = 1'b1;
        m_taken = 0;
        m_err   = 1'b0;
      end
    end
    chk("s_ready", s_ready, m_acc);
    chk("busy", if_store_busy, m_acc || (m_after == 1));
    chk("done", if_store_done, m_after == 2);
    chk("sram_wen", sram_wen, hs);
    chk("err", if_store_err, m_err);
    chk("busy_and_done", if_store_busy & if_store_done, 1'b0);
    if (hs) begin
      chk("bank_sel", sram_bank_sel, exp_sel(idx));
      chk("addr", sram_addr, exp_addr(idx));
      chk("wdata", sram_wdata, d);
      cap_sel[idx]  = sram_bank_sel;
      cap_addr[idx] = sram_addr;
      cap_data[idx] = sram_wdata;
    end
    if (sram_wen === 1'b1) wen_count++;
    if (!rn) begin
      chk("rst_bank_sel", sram_bank_sel, '0);
      chk("rst_addr", sram_addr, '0);
      chk("rst_wdata", sram_wdata, '0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_words(input bit bubbles, input int early, input bit rnd);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < TILE; i++) begin
      if (bubbles && ($urandom_range(1) == 1)) begin
        repeat ($urandom_range(3, 1)) cyc(1'b1, 1'b0, {$urandom, $urandom}, 1'b0, 1'b0);
      end
      d = rnd ? {$urandom, $urandom} : DATA_W'(i);
      cyc(1'b1, 1'b1, d, (i == TILE - 1) || (i == early), 1'b0);
    end
  endtask

  initial begin
    logic rn, v, l, st;
    tbl[0] = '{0,  3'b001, 8'd0};
    tbl[1] = '{7,  3'b001, 8'd7};
    tbl[2] = '{8,  3'b010, 8'd0};
    tbl[3] = '{16, 3'b100, 8'd0};
    tbl[4] = '{24, 3'b001, 8'd8};
    tbl[5] = '{37, 3'b010, 8'd13};
    tbl[6] = '{47, 3'b100, 8'd15};

    reset = 1'b0; start_if_store = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;

    // Reset hold with random inputs.
    repeat (3) cyc(1'b0, 1'($urandom_range(1)), {$urandom, $urandom},
                   1'($urandom_range(1)), 1'($urandom_range(1)));

    // Two-cycle start, back-to-back tile with data = index.
    wen_count = 0;
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    run_words(1'b0, -1, 1'b0);
    idle(3);
    chk("wen_count_b2b", wen_count, TILE);
    for (int k = 0; k < 7; k++) begin
      chk("tbl_sel", cap_sel[tbl[k].idx], tbl[k].sel);
      chk("tbl_addr", cap_addr[tbl[k].idx], tbl[k].addr);
      chk("tbl_data", cap_data[tbl[k].idx], DATA_W'(tbl[k].idx));
    end

    // Random bubbles with random data.
    wen_count = 0;
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    run_words(1'b1, -1, 1'b1);
    idle(3);
    chk("wen_count_bubbles", wen_count, TILE);

    // Early s_last on word 20; then start in DONE (ignored) and in IDLE (accepted).
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    run_words(1'b0, 20, 1'b0);
    chk("err_after_early_last", if_store_err, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("start_in_done_ignored", if_store_busy, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("start_in_idle_taken", if_store_busy, 1'b1);
    chk("err_cleared_on_start", if_store_err, 1'b0);
    run_words(1'b1, -1, 1'b0);
    idle(3);

    // Reset mid-tile, coinciding with the handshake of word 31, then restart.
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i <= 30; i++) cyc(1'b1, 1'b1, DATA_W'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, DATA_W'(31), 1'b0, 1'b0);
    chk("abort_wen_dropped", sram_wen, 1'b0);
    idle(4);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    run_words(1'b0, -1, 1'b0);
    idle(3);
    chk("restart_word0_sel", cap_sel[0], 3'b001);
    chk("restart_word0_addr", cap_addr[0], 8'd0);

    // Fully random traffic, including occasional resets and bad s_last.
    for (int c = 0; c < 3000; c++) begin
      rn = ($urandom_range(199) != 0);
      v  = 1'($urandom_range(1));
      st = ($urandom_range(7) == 0);
      if (m_taken == TILE - 1) l = ($urandom_range(15) != 0);
      else                     l = ($urandom_range(15) == 0);
      cyc(rn, v, {$urandom, $urandom}, l, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
